// File: rtl/vga_fb_scanout_if.sv
// Frame-buffer read bus between the VGA scanout (master) and the
// dual-port frame-buffer RAM read port (slave).
//   raddr : read address, driven by the scanout
//   rdata : RAM word for raddr, returned combinationally by the RAM
interface vga_fb_scanout_if #(
  parameter int Address_Bus = 17,
  parameter int WordSize    = 3
);
  logic [Address_Bus-1:0] raddr;
  logic [WordSize-1:0]    rdata;

  modport master (output raddr, input rdata);
  modport slave  (input raddr, output rdata);
endinterface

// File: rtl/vga_fb_scanout.sv
// VGA scanout for a 320x240 frame buffer shown at 2x upscale on 640x480@60.
// Free-running horizontal/vertical counters generate the timing; the RAM
// address is built from a line-base register and a pixel register so no
// multiplier is needed. Colour, sync, data-enable and frame-start all come
// out of one register stage, so they are mutually aligned (latency 1).
// Ports:
//   i_clk, i_rst   pixel clock; synchronous active-high reset
//   fb             frame-buffer read bus (raddr out, rdata in, same cycle)
//   o_red/o_green/o_blue  1-bit colour, forced 0 outside the visible area
//   o_hsync, o_vsync      active-low sync pulses
//   o_de                  high on visible pixels
//   o_frame_start         one-cycle pulse with the first visible pixel
module vga_fb_scanout #(
  parameter int WordSize    = 3,
  parameter int Address_Bus = 17,
  parameter int FB_WIDTH    = 320,
  parameter int FB_HEIGHT   = 240,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33
) (
  input  logic              i_clk,
  input  logic              i_rst,
  vga_fb_scanout_if.master  fb,
  output logic              o_red,
  output logic              o_green,
  output logic              o_blue,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic              o_frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic [Address_Bus-1:0] LINE_STEP = Address_Bus'(FB_WIDTH);
  localparam logic [Address_Bus-1:0] LAST_BASE = Address_Bus'((FB_HEIGHT - 1) * FB_WIDTH);

  logic [HW-1:0]          h_cnt;
  logic [VW-1:0]          v_cnt;
  logic [Address_Bus-1:0] line_base;
  logic [Address_Bus-1:0] pix;
  logic                   h_wrap;
  logic                   v_wrap;
  logic                   active;
  logic                   hsync_on;
  logic                   vsync_on;

  always_comb begin
    h_wrap   = (h_cnt == H_LAST);
    v_wrap   = (v_cnt == V_LAST);
    active   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    hsync_on = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    vsync_on = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    fb.raddr = active ? (line_base + pix) : '0;
  end

  // pix tracks h_cnt>>1 and line_base tracks (v_cnt>>1)*FB_WIDTH. Each frame
  // line is shown twice, so the base steps only after odd visible lines; the
  // LAST_BASE guard keeps it inside the buffer through vertical blanking.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      line_base <= '0;
      pix       <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      pix   <= '0;
      if (v_wrap) begin
        v_cnt     <= '0;
        line_base <= '0;
      end else begin
        v_cnt <= v_cnt + 1'b1;
        if ((v_cnt < V_VIS) && v_cnt[0] && (line_base != LAST_BASE))
          line_base <= line_base + LINE_STEP;
      end
    end else begin
      h_cnt <= h_cnt + 1'b1;
      if (h_cnt[0] && (h_cnt < H_VIS))
        pix <= pix + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_red         <= 1'b0;
      o_green       <= 1'b0;
      o_blue        <= 1'b0;
      o_de          <= 1'b0;
      o_hsync       <= 1'b1;
      o_vsync       <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      o_red         <= active & fb.rdata[2];
      o_green       <= active & fb.rdata[1];
      o_blue        <= active & fb.rdata[0];
      o_de          <= active;
      o_hsync       <= ~hsync_on;
      o_vsync       <= ~vsync_on;
      o_frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout using a scaled-down raster so several whole
// frames fit in a short run. The reference model derives every expected
// output from the cycle index since reset release using plain division.
module tb_vga_fb_scanout;
  localparam int AW  = 17;
  localparam int WS  = 3;
  localparam int FBW = 20;
  localparam int FBH = 12;
  localparam int HA  = 40;
  localparam int HFP = 4;
  localparam int HS  = 6;
  localparam int HBP = 5;
  localparam int VA  = 24;
  localparam int VFP = 3;
  localparam int VS  = 2;
  localparam int VBP = 4;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int MW  = $clog2(FBW * FBH);

  logic clk = 1'b0;
  logic rst;
  logic red, green, blue, hsync, vsync, de, fs;
  logic fill_ones;
  logic [2:0] mem [FBW*FBH];

  always #20 clk = ~clk;

  vga_fb_scanout_if #(.Address_Bus(AW), .WordSize(WS)) bus ();

  // Combinational RAM read port.
  assign bus.rdata = fill_ones ? 3'b111 : mem[bus.raddr[MW-1:0]];

  vga_fb_scanout #(
    .WordSize(WS), .Address_Bus(AW), .FB_WIDTH(FBW), .FB_HEIGHT(FBH),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
  ) dut (
    .i_clk(clk), .i_rst(rst), .fb(bus),
    .o_red(red), .o_green(green), .o_blue(blue),
    .o_hsync(hsync), .o_vsync(vsync), .o_de(de), .o_frame_start(fs)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Model state: k = counter position index, prev = index whose outputs are
  // currently registered (-1 means reset values).
  int k = 0;
  int prev = -1;
  logic [2:0] prev_col = 3'b000;

  int cyc = 0;
  int de_rise_t = -1, de_fall_t = -1, hs_fall_t = -1, vs_fall_t = -1, fs_t = -1;
  logic last_de = 1'b0, last_hs = 1'b1, last_vs = 1'b1;
  int nfs = 0;
  int blank_bad = 0, raddr_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit act_of(input int t);
    int h, v;
    h = t % HT;
    v = (t / HT) % VT;
    return (h < HA) && (v < VA);
  endfunction

  function automatic int addr_of(input int t);
    int h, v;
    h = t % HT;
    v = (t / HT) % VT;
    return act_of(t) ? (v / 2) * FBW + h / 2 : 0;
  endfunction

  function automatic logic [6:0] outs_of(input int t, input logic [2:0] col);
    int h, v;
    logic hs_e, vs_e;
    h = t % HT;
    v = (t / HT) % VT;
    hs_e = !((h >= HA + HFP) && (h <= HA + HFP + HS - 1));
    vs_e = !((v >= VA + VFP) && (v <= VA + VFP + VS - 1));
    return {col, hs_e, vs_e, act_of(t), (h == 0) && (v == 0)};
  endfunction

  task automatic tick();
    logic [23:0] obs, exp;
    obs = {bus.raddr, red, green, blue, hsync, vsync, de, fs};
    exp[23:7] = 17'(addr_of(k));
    exp[6:0]  = (prev < 0) ? 7'b000_1100 : outs_of(prev, prev_col);
    check("scan", {8'h00, obs}, {8'h00, exp});

    if (de && !last_de) begin
      if (de_rise_t >= 0 && cyc - de_rise_t < 2 * HT) check("line_period", cyc - de_rise_t, HT);
      de_rise_t = cyc;
    end
    if (!de && last_de && de_rise_t >= 0) begin
      check("de_width", cyc - de_rise_t, HA);
      de_fall_t = cyc;
    end
    if (!hsync && last_hs) begin
      if (de_fall_t >= 0 && cyc - de_fall_t < HT) check("hs_after_de", cyc - de_fall_t, HFP);
      hs_fall_t = cyc;
    end
    if (hsync && !last_hs && hs_fall_t >= 0) check("hs_width", cyc - hs_fall_t, HS);
    if (!vsync && last_vs) begin
      if (fs_t >= 0) check("vs_start", cyc - fs_t, (VA + VFP) * HT);
      vs_fall_t = cyc;
    end
    if (vsync && !last_vs && vs_fall_t >= 0) check("vs_width", cyc - vs_fall_t, VS * HT);
    if (fs) begin
      if (fs_t >= 0) check("frame_period", cyc - fs_t, FRAME);
      fs_t = cyc;
      nfs++;
    end
    if (!de && {red, green, blue} != 3'b000) blank_bad++;
    if (!act_of(k) && bus.raddr != '0) raddr_bad++;
    last_de = de;
    last_hs = hsync;
    last_vs = vsync;

    @(posedge clk);
    if (rst) begin
      k = 0;
      prev = -1;
      prev_col = 3'b000;
      de_rise_t = -1; de_fall_t = -1; hs_fall_t = -1; vs_fall_t = -1; fs_t = -1;
    end else begin
      prev = k;
      prev_col = act_of(k) ? (fill_ones ? 3'b111 : mem[addr_of(k)]) : 3'b000;
      k++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  initial begin
    int seq [6];
    seq = '{0, 0, 1, 1, 2, 2};
    rst = 1'b1;
    fill_ones = 1'b0;
    for (int i = 0; i < FBW * FBH; i++) mem[i] = 3'($urandom_range(0, 7));
    mem[0] = 3'b101;
    repeat (2) @(posedge clk);
    @(negedge clk);
    repeat (4) tick();

    // Reset release: origin address, then first pixel registered.
    rst = 1'b0;
    check("release_raddr", 32'(bus.raddr), 0);
    tick();
    check("first_pixel", {27'd0, de, fs, red, green, blue}, 32'b11101);
    for (int i = 1; i < 6; i++) begin
      check("line0_addr", 32'(bus.raddr), seq[i]);
      tick();
    end

    run_to(HT);
    check("line1_start", 32'(bus.raddr), 0);
    run_to(HT + HA - 1);
    check("line1_end", 32'(bus.raddr), FBW - 1);
    run_to(2 * HT);
    check("line2_start", 32'(bus.raddr), FBW);
    run_to((VA - 1) * HT + HA - 1);
    check("last_addr", 32'(bus.raddr), FBW * FBH - 1);

    // Blanking frame with all-ones RAM data.
    run_to(2 * FRAME + 2);
    fill_ones = 1'b1;
    blank_bad = 0;
    raddr_bad = 0;
    run_to(3 * FRAME + 2);
    check("blank_colour", blank_bad, 0);
    check("blank_raddr", raddr_bad, 0);
    check("fs_count", nfs, 4);
    fill_ones = 1'b0;

    // Mid-frame reset at (h=30, v=20).
    run_to(3 * FRAME + 20 * HT + 30);
    rst = 1'b1;
    repeat (3) tick();
    check("midrst_outs", {25'd0, red, green, blue, hsync, vsync, de, fs}, 32'b000_1100);
    rst = 1'b0;
    check("midrst_raddr", 32'(bus.raddr), 0);
    tick();
    check("restart_fs", {31'd0, fs}, 1);
    check("restart_raddr", 32'(bus.raddr), 0);
    run_to(3 * HT);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/vga_fb_scanout.md
Name: vga_fb_scanout

Overview:
- Read-side companion of the dual-port frame-buffer RAM (320x240, 3-bit RGB words, combinational read port).
- Generates 640x480@60 VGA timing from the 25.175 MHz pixel clock and scans the frame buffer at 2x upscale, one address per pixel.
- Drives the RAM read address and converts the returned word to 1-bit R/G/B with hsync, vsync and data-enable.
- Emits a frame-start pulse so the pixel writer can synchronise updates.

Parameters:
- WordSize, 3, width of RAM word; bit2=R, bit1=G, bit0=B
- Address_Bus, 17, RAM address width
- FB_WIDTH, 320, frame-buffer pixels per line
- FB_HEIGHT, 240, frame-buffer lines
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- i_clk  input  1  pixel clock; all logic on posedge
- i_rst  input  1  synchronous reset, active-high
- o_raddr  output  Address_Bus  frame-buffer read address (to RAM i_raddr)
- i_rdata  input  WordSize  RAM read data (from RAM o_read), valid same cycle as o_raddr
- o_red  output  1  red
- o_green  output  1  green
- o_blue  output  1  blue
- o_hsync  output  1  horizontal sync, active-low
- o_vsync  output  1  vertical sync, active-low
- o_de  output  1  data-enable, high on visible pixels
- o_frame_start  output  1  one-cycle pulse on first visible pixel of each frame

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - v_cnt runs 0..V_TOTAL-1, where V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - h_cnt increments every cycle and wraps to 0 at H_TOTAL-1.
  - v_cnt increments when h_cnt wraps, and wraps to 0 at V_TOTAL-1 with h_cnt=H_TOTAL-1.
  - Frame period is 420000 cycles.
- Regions:
  - active = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - hsync asserted (low) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - vsync asserted (low) for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491].
- Address (combinational from counters):
  - In active region, o_raddr = (v_cnt>>1)*FB_WIDTH + (h_cnt>>1).
  - Outside the active region, o_raddr = 0.
  - Range is 0..76799, never exceeding FB_WIDTH*FB_HEIGHT-1.
  - Implement with incrementing line-base and pixel registers, not a multiplier. Line base advances by FB_WIDTH after every odd visible line and resets to 0 at frame wrap.
- Output stage (one register stage, latency 1):
  - o_red/o_green/o_blue <= active ? i_rdata[2]/[1]/[0] : 0.
  - o_de <= active.
  - o_hsync and o_vsync are registered from the same cycle's counters, so sync, de and colour are mutually aligned.
- Frame start: o_frame_start <= (h_cnt==0 && v_cnt==0). It is high in the same cycle o_de first rises in a frame.
- Reset:
  - While i_rst is high: h_cnt=0, v_cnt=0, line base=0.
  - Register values while i_rst is high: o_red/o_green/o_blue=0, o_de=0, o_hsync=1, o_vsync=1, o_frame_start=0.
  - o_raddr is 0 during reset because counters are at the origin.
  - First cycle after i_rst falls: counters at (0,0). The next edge registers o_de=1, o_frame_start=1 and the pixel at address 0.
  - Reset mid-frame aborts the frame immediately. There is no partial-line completion; timing restarts from (0,0).
- i_rdata is ignored (colour forced 0) whenever active is low.
- No handshake with the writer; RAM write-port contention is the RAM's concern. o_frame_start is the only sync aid.

Test Plan:
- Reset release with i_rdata=3'b101: 1st post-reset edge gives o_de=1, o_frame_start=1, o_red=1, o_green=0, o_blue=1; o_raddr=0 at counters (0,0).
- Line scan: o_raddr sequence for h_cnt=0..5 on line 0 is 0,0,1,1,2,2. Line 1 repeats 0..319; line 2 starts at 320. At (h=639, v=479) o_raddr=76799.
- Horizontal timing: o_de high for exactly 640 cycles per line and o_hsync low for exactly 96 cycles. The hsync falling edge comes 16 cycles after o_de falls; line period is 800 cycles.
- Vertical timing: o_vsync low for exactly 1600 cycles (2 lines) per frame, starting 10 lines after the last visible line. o_frame_start pulses exactly once per 420000 cycles.
- Blanking: drive i_rdata=3'b111 constantly; o_red/o_green/o_blue are 0 whenever o_de=0, and o_raddr is 0 during blanking.
- Mid-frame reset: assert i_rst for 3 cycles at (h=300, v=200). All outputs take reset values, and timing restarts with o_frame_start 1 cycle after release with o_raddr=0.
